// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - RV32M iterative multiply/divide sequencer (shift-add multiplier, restoring divider).
// Optional macro MDU_FAST_MUL_EN: single-cycle multiplies via the IDLE->DONE fast path.
module mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [7:0]      mdu_info_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      r_state;
    logic        r_mul, r_mul_lo, r_quot, r_neg, r_rem_neg;
    logic [31:0] r_a, r_b, r_prem, r_result;
    logic [63:0] r_acc;
    logic [5:0]  r_cnt;

    logic        w_accept, w_is_mul, w_a_signed, w_b_signed, w_sa, w_sb;
    logic        w_div_zero, w_ovf, w_fast, w_div_ok;
    logic [31:0] w_abs_a, w_abs_b, w_fast_result, w_calc_result, w_quo_next, w_prem_next;
    logic [32:0] w_mul_sum, w_div_shift;
    logic [63:0] w_mul_next, w_prod;

    assign w_accept   = valid_i & (r_state == S_IDLE) & ~flush_i & (|mdu_info_i);
    assign w_is_mul   = |mdu_info_i[7:4];
    assign w_a_signed = mdu_info_i[7] | mdu_info_i[6] | mdu_info_i[5] | mdu_info_i[3] | mdu_info_i[1];
    assign w_b_signed = mdu_info_i[7] | mdu_info_i[6] | mdu_info_i[3] | mdu_info_i[1];
    assign w_sa       = w_a_signed & rs1_data_i[31];
    assign w_sb       = w_b_signed & rs2_data_i[31];
    assign w_abs_a    = w_sa ? -rs1_data_i : rs1_data_i;
    assign w_abs_b    = w_sb ? -rs2_data_i : rs2_data_i;
    assign w_div_zero = ~w_is_mul & (rs2_data_i == 32'd0);
    assign w_ovf      = (mdu_info_i[3] | mdu_info_i[1]) & (rs1_data_i == 32'h8000_0000)
                      & (rs2_data_i == 32'hFFFF_FFFF);

`ifdef MDU_FAST_MUL_EN
    logic signed [63:0] w_sa64, w_sb64;
    logic [63:0]        w_fast_prod;
    assign w_sa64      = {{32{w_sa}}, rs1_data_i};
    assign w_sb64      = {{32{w_sb}}, rs2_data_i};
    assign w_fast_prod = w_sa64 * w_sb64;
    assign w_fast      = w_div_zero | w_ovf | w_is_mul;
`else
    assign w_fast      = w_div_zero | w_ovf;
`endif

    always_comb begin
        w_fast_result = '0;
        if (w_div_zero)
            w_fast_result = (mdu_info_i[3] | mdu_info_i[2]) ? 32'hFFFF_FFFF : rs1_data_i;
        else if (w_ovf)
            w_fast_result = mdu_info_i[3] ? 32'h8000_0000 : 32'd0;
`ifdef MDU_FAST_MUL_EN
        else if (mdu_info_i[7])
            w_fast_result = w_fast_prod[31:0];
        else if (w_is_mul)
            w_fast_result = w_fast_prod[63:32];
`endif
    end

    // Multiplier sits in r_acc[31:0] and shifts out LSB-first as the product fills the top.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};
    assign w_prod     = r_neg ? -w_mul_next : w_mul_next;

    // Dividend sits in r_acc[31:0]; quotient bits replace it from the LSB end.
    assign w_div_shift = {r_prem, r_acc[31]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    assign w_prem_next = w_div_ok ? (w_div_shift[31:0] - r_b) : w_div_shift[31:0];
    assign w_quo_next  = {r_acc[30:0], w_div_ok};

    always_comb begin
        w_calc_result = '0;
        if (r_mul)
            w_calc_result = r_mul_lo ? w_prod[31:0] : w_prod[63:32];
        else if (r_quot)
            w_calc_result = r_neg ? -w_quo_next : w_quo_next;
        else
            w_calc_result = r_rem_neg ? -w_prem_next : w_prem_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_mul     <= 1'b0;
            r_mul_lo  <= 1'b0;
            r_quot    <= 1'b0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_prem    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_mul     <= w_is_mul;
                    r_mul_lo  <= mdu_info_i[7];
                    r_quot    <= mdu_info_i[3] | mdu_info_i[2];
                    r_neg     <= w_sa ^ w_sb;
                    r_rem_neg <= w_sa;
                    r_a       <= w_abs_a;
                    r_b       <= w_abs_b;
                    r_prem    <= '0;
                    r_acc     <= {32'd0, w_is_mul ? w_abs_b : w_abs_a};
                    r_cnt     <= '0;
                    if (w_fast) begin
                        r_result <= w_fast_result;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: if (flush_i) begin
                    r_state <= S_IDLE;
                end else begin
                    if (r_mul) begin
                        r_acc <= w_mul_next;
                    end else begin
                        r_acc[31:0] <= w_quo_next;
                        r_prem      <= w_prem_next;
                    end
                    if (r_cnt == 6'd31) begin
                        r_result <= w_calc_result;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (r_state == S_IDLE);
    assign stall_o  = w_accept | (r_state == S_CALC);
    assign valid_o  = (r_state == S_DONE) & ~flush_i;
    assign result_o = r_result;
endmodule
